tlb_arbiter: RTL
================

Name: tlb_arbiter

Overview:
- Shares one TLB lookup port between two requesters: requester 0 is instruction fetch, requester 1 is the memory stage.
- Performs round-robin arbitration and latches the winning virtual page.
- Holds the TLB valid high for the whole multi-cycle translation delay.
- Returns the physical page and exception flag to the owning requester with a one-cycle response pulse.
- Aborts cleanly if the owner withdraws its request, and reports a timeout if the TLB never hits.

Parameters:
- WIDTH, `PAGE_WIDTH: virtual and physical page width.
- TIMEOUT, 32: maximum LOOKUP cycles before a forced error response. Must be greater than `TLB_DELAY+2`.
- CNT_WIDTH, 6: width of the timeout counter. Must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clk, input, 1: clock. Everything is rising-edge.
- reset, input, 1: synchronous reset, active-high.
- req0_valid, input, 1: fetch requests a translation. Held high until rsp0_valid.
- req0_vpage, input, WIDTH: fetch virtual page.
- req1_valid, input, 1: memory stage requests a translation. Held high until rsp1_valid.
- req1_vpage, input, WIDTH: memory stage virtual page.
- rsp0_valid, output, 1: one-cycle response pulse to requester 0.
- rsp1_valid, output, 1: one-cycle response pulse to requester 1.
- rsp_ppage, output, WIDTH: translated page. Shared bus, qualified by rsp0_valid or rsp1_valid.
- rsp_exception, output, 1: translation exception or timeout. Qualified the same way.
- rsp_timeout, output, 1: response was forced by timeout.
- tlb_valid, output, 1: valid to the TLB.
- tlb_virtual_page, output, WIDTH: page presented to the TLB.
- tlb_physical_page, input, WIDTH: TLB result.
- tlb_exception, input, 1: TLB exception.
- tlb_hit, input, 1: TLB hit, combinational from the TLB.
- busy, output, 1: state is not IDLE.

Behaviour:
- All outputs are registered, except tlb_valid, tlb_virtual_page and busy, which decode directly from state registers.
- Reset values:
  - state=IDLE.
  - Every output = 0.
  - owner=0.
  - last_grant=1, so requester 0 wins the first conflict.
  - Latched vpage=0; counter=0.
- IDLE:
  - tlb_valid=0.
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch owner and its vpage, set last_grant=owner, clear the counter, go to LOOKUP.
  - With no request, stay in IDLE.
- LOOKUP:
  - tlb_valid=1 and tlb_virtual_page=latched vpage, for every cycle spent in LOOKUP.
  - The counter increments each cycle.
  - Priority 1, abort: the owner's req_valid is low. Go to IDLE with no response. tlb_valid drops the next cycle, which restarts the TLB delay chain.
  - Priority 2, hit: tlb_hit=1. Capture rsp_ppage=tlb_physical_page, rsp_exception=tlb_exception, rsp_timeout=0. Go to RESP.
  - Priority 3, timeout: counter==TIMEOUT-1 with no hit. Capture rsp_ppage=0, rsp_exception=1, rsp_timeout=1. Go to RESP.
  - Otherwise stay in LOOKUP. The non-owner's req_valid is ignored.
- RESP:
  - The owner's rsp valid is high for exactly this one cycle; tlb_valid=0.
  - Next state is always IDLE.
  - rsp_ppage, rsp_exception and rsp_timeout hold their values until the next capture.
- Latency:
  - Resident entry: request seen in IDLE at cycle T, LOOKUP at T+1 (combinational hit), rsp at T+2.
  - Miss: rsp comes one cycle after the LOOKUP cycle in which tlb_hit first appears.
- Requester rule: deassert req_valid in the cycle after the rsp pulse. A req_valid still high in IDLE is treated as a new request.
- Back-to-back: when both requesters are continuously asserted, grants alternate 0,1,0,1… There is no starvation.
- reset mid-LOOKUP or mid-RESP: return to IDLE next cycle, no response, tlb_valid=0, last_grant=1.
- A request arriving while busy waits. It is arbitrated in the first IDLE cycle.

Test Plan:
1. Resident hit. The TLB model hits immediately on page 0x12, returning ppage 0x13. Assert req0 at cycle 0. Required: tlb_valid=1 at cycle 1; rsp0_valid=1 at cycle 2 with rsp_ppage=0x13, exception=0, timeout=0; tlb_valid=0 at cycle 2.
2. Miss with `TLB_DELAY`=3. The TLB model hits in the 5th LOOKUP cycle. Assert req1 with page 0x40. Required: tlb_valid high for exactly 5 cycles; rsp1_valid one cycle later with rsp_ppage=0x41; rsp0_valid stays 0 throughout.
3. Conflict. req0 and req1 rise together from reset, and both re-request right after each response. Required grant order 0,1,0,1, checked via tlb_virtual_page and the rsp pulses. Neither requester waits more than one full transaction.
4. Abort. The owner drops req_valid in the 2nd LOOKUP cycle. Required: state returns to IDLE, no rsp pulse, tlb_valid falls the next cycle, and a pending req from the other requester is granted in the following cycle.
5. Timeout. The TLB model never hits, with TIMEOUT=32. Required: tlb_valid high for exactly 32 cycles, then an rsp pulse with rsp_exception=1, rsp_timeout=1, rsp_ppage=0.
6. Exception and reset. Page 0 hits with tlb_exception=1, which must respond with rsp_exception=1, timeout=0. Then assert reset during the 3rd LOOKUP cycle of another request: all outputs must be 0 the next cycle, and the next grant goes to req0.

Source files
------------

// File: rtl/tlb_arbiter.sv
// Round-robin arbiter sharing one TLB lookup port between instruction fetch (0)
// and the memory stage (1), with abort on withdrawal and a lookup timeout.
module tlb_arbiter #(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_vpage,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_vpage,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_ppage,
  output logic             rsp_exception,
  output logic             rsp_timeout,
  output logic             tlb_valid,
  output logic [WIDTH-1:0] tlb_virtual_page,
  input  logic [WIDTH-1:0] tlb_physical_page,
  input  logic             tlb_exception,
  input  logic             tlb_hit,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e               state_q;
  logic                 owner_q;
  logic                 last_grant_q;
  logic [WIDTH-1:0]     vpage_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 rsp0_valid_q;
  logic                 rsp1_valid_q;
  logic [WIDTH-1:0]     rsp_ppage_q;
  logic                 rsp_exception_q;
  logic                 rsp_timeout_q;

  logic req_any;
  logic grant_owner;
  logic owner_req;
  logic timeout_hit;

  // On a conflict the requester that did not win last time is chosen.
  assign req_any     = req0_valid | req1_valid;
  assign grant_owner = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign owner_req   = owner_q ? req1_valid : req0_valid;
  assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      vpage_q         <= '0;
      cnt_q           <= '0;
      rsp0_valid_q    <= 1'b0;
      rsp1_valid_q    <= 1'b0;
      rsp_ppage_q     <= '0;
      rsp_exception_q <= 1'b0;
      rsp_timeout_q   <= 1'b0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_any) begin
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            vpage_q      <= grant_owner ? req1_vpage : req0_vpage;
            cnt_q        <= '0;
            state_q      <= LOOKUP;
          end
        end
        LOOKUP: begin
          cnt_q <= cnt_q + 1'b1;
          if (!owner_req) begin
            // Withdrawal wins over a same-cycle hit; nobody is left to answer.
            state_q <= IDLE;
          end else if (tlb_hit) begin
            rsp_ppage_q     <= tlb_physical_page;
            rsp_exception_q <= tlb_exception;
            rsp_timeout_q   <= 1'b0;
            rsp0_valid_q    <= ~owner_q;
            rsp1_valid_q    <= owner_q;
            state_q         <= RESP;
          end else if (timeout_hit) begin
            rsp_ppage_q     <= '0;
            rsp_exception_q <= 1'b1;
            rsp_timeout_q   <= 1'b1;
            rsp0_valid_q    <= ~owner_q;
            rsp1_valid_q    <= owner_q;
            state_q         <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid       = rsp0_valid_q;
  assign rsp1_valid       = rsp1_valid_q;
  assign rsp_ppage        = rsp_ppage_q;
  assign rsp_exception    = rsp_exception_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign tlb_valid        = (state_q == LOOKUP);
  assign tlb_virtual_page = vpage_q;
  assign busy             = (state_q != IDLE);

endmodule
